// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader_pkg
// Description : Shared types and constants for the serial program loader:
//               loader state encoding, frame sync byte and default image size.
//               The CHECK state only exists when PROG_LOADER_CHECKSUM_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
package prog_loader_pkg;

    // First byte of every frame; anything else received in IDLE is discarded.
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Largest accepted image in 32-bit words (2^(ADDR_W-2) for ADDR_W = 10).
    localparam int MAX_WORDS_DEFAULT = 256;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN0  = 3'd1,
        ST_LEN1  = 3'd2,
        ST_DATA  = 3'd3,
`ifdef PROG_LOADER_CHECKSUM_EN
        ST_CHECK = 3'd4,
`endif
        ST_DONE  = 3'd5,
        ST_ERROR = 3'd6
    } state_t;

endpackage : prog_loader_pkg
`default_nettype wire

// File: rtl/prog_loader_byte_assembler.sv
`default_nettype none
// ============================================================================
// Module      : byte_assembler
// Description : Collects four stream bytes, LSB first, into a 32-bit word and
//               emits a one-cycle word_valid pulse together with the word.
//               Cleared by Reset (asynchronous) or i_clear (synchronous).
// Ports       : clk, Reset      - clock, async active-high reset
//               i_clear         - drop any partial word, byte index to 0
//               i_byte_en       - i_byte is part of a data word this cycle
//               i_byte          - stream byte
//               o_byte_idx      - position (0..3) of the next byte in its word
//               o_word_valid    - registered one-cycle strobe, word complete
//               o_word          - last completed word (held until the next)
// Revision    : 1.0 - initial release
// ============================================================================
module byte_assembler (
    input  logic        clk,
    input  logic        Reset,
    input  logic        i_clear,
    input  logic        i_byte_en,
    input  logic [7:0]  i_byte,
    output logic [1:0]  o_byte_idx,
    output logic        o_word_valid,
    output logic [31:0] o_word
);

    logic [1:0]  r_cnt;
    logic [31:0] r_shift;
    logic        r_word_valid;
    logic [31:0] r_word;

    // New bytes enter at the top so the first (least significant) byte ends
    // up in bits [7:0] once four bytes have been shifted in.
    logic [31:0] w_shift_next;
    assign w_shift_next = {i_byte, r_shift[31:8]};

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_cnt        <= 2'd0;
            r_shift      <= 32'd0;
            r_word_valid <= 1'b0;
            r_word       <= 32'd0;
        end else if (i_clear) begin
            r_cnt        <= 2'd0;
            r_shift      <= 32'd0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= 1'b0;
            if (i_byte_en) begin
                r_shift <= w_shift_next;
                r_cnt   <= r_cnt + 2'd1;
                if (r_cnt == 2'd3) begin
                    r_word_valid <= 1'b1;
                    r_word       <= w_shift_next;
                end
            end
        end
    end

    assign o_byte_idx   = r_cnt;
    assign o_word_valid = r_word_valid;
    assign o_word       = r_word;

endmodule : byte_assembler
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Serial program loader for the single-cycle RV32I core.
//               Parses the frame  A5 | len_lo | len_hi | 4*N data bytes
//               [| checksum], writes each little-endian word to instruction
//               memory and holds the core in reset until the image is done.
//               Optional feature macro: PROG_LOADER_CHECKSUM_EN adds a
//               trailing XOR checksum byte and the CHECK state.
// Ports       : clk, Reset        - clock, async active-high reset
//               start             - abort / re-arm pulse (beats a same-cycle byte)
//               in_data/in_valid/in_ready - byte stream handshake
//               imem_we/imem_addr/imem_wd - instruction memory write port
//               core_reset        - high except after a successful load
//               done / error      - image loaded / frame rejected
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = MAX_WORDS_DEFAULT
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wd,
    output logic              core_reset,
    output logic              done,
    output logic              error
);

    localparam int              IDX_W       = ADDR_W - 2;
    localparam logic [16:0]     c_max_words = 17'(MAX_WORDS);
    localparam logic [IDX_W-1:0] c_idx_one  = {{(IDX_W-1){1'b0}}, 1'b1};

    state_t             r_state;
    logic [7:0]         r_len_lo;
    logic [IDX_W-1:0]   r_last_idx;
    logic [IDX_W-1:0]   r_word_idx;
    logic [ADDR_W-1:0]  r_imem_addr;
    logic               r_done;
    logic               r_error;
    logic               r_core_reset;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]         r_csum;
`endif

    logic               w_accept;
    logic [15:0]        w_len;
    logic               w_byte_en;
    logic [1:0]         w_byte_idx;
    logic               w_word_valid;
    logic [31:0]        w_word;

    assign in_ready  = (r_state != ST_DONE) && (r_state != ST_ERROR);
    assign w_accept  = in_valid && in_ready;
    assign w_len     = {in_data, r_len_lo};
    // A data byte dropped by a same-cycle start must not reach the assembler.
    assign w_byte_en = w_accept && (r_state == ST_DATA) && !start;

    byte_assembler u_byte_assembler (
        .clk          (clk),
        .Reset        (Reset),
        .i_clear      (start),
        .i_byte_en    (w_byte_en),
        .i_byte       (in_data),
        .o_byte_idx   (w_byte_idx),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state      <= ST_IDLE;
            r_len_lo     <= 8'd0;
            r_last_idx   <= '0;
            r_word_idx   <= '0;
            r_imem_addr  <= '0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_core_reset <= 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_csum       <= 8'd0;
`endif
        end else if (start) begin
            r_state      <= ST_IDLE;
            r_word_idx   <= '0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_core_reset <= 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_csum       <= 8'd0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && (in_data == SYNC_BYTE)) begin
                        r_state    <= ST_LEN0;
                        r_word_idx <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                        r_csum     <= 8'd0;
`endif
                    end
                end
                ST_LEN0: begin
                    if (w_accept) begin
                        r_len_lo <= in_data;
                        r_state  <= ST_LEN1;
`ifdef PROG_LOADER_CHECKSUM_EN
                        r_csum   <= r_csum ^ in_data;
`endif
                    end
                end
                ST_LEN1: begin
                    if (w_accept) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        r_csum <= r_csum ^ in_data;
`endif
                        // Index of the final word; only meaningful when N > 0.
                        r_last_idx <= IDX_W'(w_len) - c_idx_one;
                        if ({1'b0, w_len} > c_max_words) begin
                            r_state <= ST_ERROR;
                            r_error <= 1'b1;
                        end else if (w_len != 16'd0) begin
                            r_state <= ST_DATA;
                        end else begin
`ifdef PROG_LOADER_CHECKSUM_EN
                            r_state <= ST_CHECK;
`else
                            r_state      <= ST_DONE;
                            r_done       <= 1'b1;
                            r_core_reset <= 1'b0;
`endif
                        end
                    end
                end
                ST_DATA: begin
                    if (w_accept) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        r_csum <= r_csum ^ in_data;
`endif
                        // The assembler publishes the word on the same edge,
                        // so the address register lines up with imem_we.
                        if (w_byte_idx == 2'd3) begin
                            r_imem_addr <= {r_word_idx, 2'b00};
                            r_word_idx  <= r_word_idx + c_idx_one;
                            if (r_word_idx == r_last_idx) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                                r_state <= ST_CHECK;
`else
                                r_state      <= ST_DONE;
                                r_done       <= 1'b1;
                                r_core_reset <= 1'b0;
`endif
                            end
                        end
                    end
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (w_accept) begin
                        if (in_data == r_csum) begin
                            r_state      <= ST_DONE;
                            r_done       <= 1'b1;
                            r_core_reset <= 1'b0;
                        end else begin
                            r_state <= ST_ERROR;
                            r_error <= 1'b1;
                        end
                    end
                end
`endif
                // DONE and ERROR wait for start, handled above.
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

    assign imem_we    = w_word_valid;
    assign imem_wd    = w_word;
    assign imem_addr  = r_imem_addr;
    assign core_reset = r_core_reset;
    assign done       = r_done;
    assign error      = r_error;

endmodule : prog_loader
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_loader
// Description : Self-checking bench for prog_loader. Frames are built as byte
//               queues; a frame parser derives the expected writes and final
//               outcome, which are compared with the DUT's write strobes and
//               status outputs. Honours PROG_LOADER_CHECKSUM_EN like the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    localparam int ADDR_W = 10;
    localparam int MAXW   = 256;

    logic              clk;
    logic              Reset;
    logic              start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wd;
    logic              core_reset;
    logic              done;
    logic              error;

    prog_loader #(
        .ADDR_W    (ADDR_W),
        .MAX_WORDS (MAXW)
    ) dut (
        .clk        (clk),
        .Reset      (Reset),
        .start      (start),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wd    (imem_wd),
        .core_reset (core_reset),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  stream[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    int          exp_wr_idx[$];
    logic        exp_done;
    logic        exp_error;
    int          exp_consumed;

    logic [31:0] wlog_addr[$];
    logic [31:0] wlog_data[$];

    // Every write strobe seen by the bench, sampled mid-cycle.
    always @(negedge clk) begin
        if (!Reset && imem_we === 1'b1) begin
            wlog_addr.push_back(32'(imem_addr));
            wlog_data.push_back(imem_wd);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Frame parser: walks the byte list the way the frame is defined and
    // records which words land where, and how the frame ends.
    function automatic void model_parse();
        int i = 0;
        int n;
        logic [7:0]  cs;
        logic [31:0] w;
        exp_addr.delete();
        exp_data.delete();
        exp_wr_idx.delete();
        exp_done  = 1'b0;
        exp_error = 1'b0;
        while (i < stream.size() && stream[i] != 8'hA5) i++;
        if (i >= stream.size()) begin
            exp_consumed = stream.size();
            return;
        end
        i++;
        n  = int'({stream[i+1], stream[i]});
        cs = stream[i] ^ stream[i+1];
        i += 2;
        if (n > MAXW) begin
            exp_error    = 1'b1;
            exp_consumed = i;
            return;
        end
        for (int k = 0; k < n; k++) begin
            w  = {stream[i+3], stream[i+2], stream[i+1], stream[i]};
            cs = cs ^ stream[i] ^ stream[i+1] ^ stream[i+2] ^ stream[i+3];
            exp_addr.push_back(32'(4 * k));
            exp_data.push_back(w);
            exp_wr_idx.push_back(i + 3);
            i += 4;
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        if (stream[i] == cs) exp_done = 1'b1;
        else                 exp_error = 1'b1;
        i++;
`else
        exp_done = 1'b1;
`endif
        exp_consumed = i;
    endfunction

    task automatic idle_cycle();
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic start_pulse();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start_done", 32'(done), 32'd0);
        chk("start_error", 32'(error), 32'd0);
        chk("start_core_reset", 32'(core_reset), 32'd1);
        chk("start_in_ready", 32'(in_ready), 32'd1);
    endtask

    // Append the XOR of stream[from..end] (checksum build only).
    task automatic add_cs(input int from, input logic [7:0] flip);
`ifdef PROG_LOADER_CHECKSUM_EN
        logic [7:0] cs = 8'd0;
        for (int i = from; i < stream.size(); i++) cs ^= stream[i];
        stream.push_back(cs ^ flip);
`else
        if (flip != 8'd0 && from < 0) stream.push_back(8'd0);
`endif
    endtask

    task automatic build_frame(input int n, input int garbage, input logic [7:0] flip);
        logic [7:0] b;
        stream.delete();
        for (int g = 0; g < garbage; g++) begin
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h5A;
            stream.push_back(b);
        end
        stream.push_back(8'hA5);
        stream.push_back(8'(n));
        stream.push_back(8'(n >> 8));
        if (n <= MAXW) begin
            for (int k = 0; k < 4 * n; k++) stream.push_back(8'($urandom));
            add_cs(garbage + 1, flip);
        end
    endtask

    task automatic run_stream(input bit gaps);
        int wp = 0;
        model_parse();
        wlog_addr.delete();
        wlog_data.delete();
        for (int i = 0; i < exp_consumed; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) idle_cycle();
            send_byte(stream[i]);
            if (wp < exp_wr_idx.size() && exp_wr_idx[wp] == i) begin
                chk("wr_we", 32'(imem_we), 32'd1);
                chk("wr_addr", 32'(imem_addr), exp_addr[wp]);
                chk("wr_data", imem_wd, exp_data[wp]);
                wp++;
            end else begin
                chk("no_we", 32'(imem_we), 32'd0);
            end
        end
        chk("end_done", 32'(done), 32'(exp_done));
        chk("end_error", 32'(error), 32'(exp_error));
        chk("end_core_reset", 32'(core_reset), 32'(!exp_done));
        chk("end_in_ready", 32'(in_ready), 32'(!(exp_done || exp_error)));
        idle_cycle();
        idle_cycle();
        chk("wlog_count", 32'(wlog_addr.size()), 32'(exp_addr.size()));
        for (int k = 0; k < wlog_addr.size() && k < exp_addr.size(); k++) begin
            chk("wlog_addr", wlog_addr[k], exp_addr[k]);
            chk("wlog_data", wlog_data[k], exp_data[k]);
        end
    endtask

    initial begin
        Reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_wd", imem_wd, 32'd0);
        chk("rst_core_reset", 32'(core_reset), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        Reset = 1'b0;
        idle_cycle();

        // Two-word frame, back-to-back bytes.
        stream = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                   8'hB3, 8'h00, 8'h00, 8'h00};
        add_cs(1, 8'h00);
        run_stream(1'b0);

`ifdef PROG_LOADER_CHECKSUM_EN
        // Same frame with a wrong checksum byte.
        start_pulse();
        stream = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                   8'hB3, 8'h00, 8'h00, 8'h00, 8'h00};
        run_stream(1'b0);
`endif

        // Leading garbage, then an empty image.
        start_pulse();
        stream = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h00};
        add_cs(4, 8'h00);
        run_stream(1'b0);

        // Oversized length: rejected right after the length bytes.
        start_pulse();
        stream = '{8'hA5, 8'h01, 8'h01};
        run_stream(1'b0);

        // Largest legal image.
        start_pulse();
        build_frame(MAXW, 0, 8'h00);
        run_stream(1'b0);

        // Reset in the middle of a frame, then a fresh one-word frame.
        start_pulse();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hDE);
        send_byte(8'hAD);
        Reset = 1'b1;
        #2;
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_we", 32'(imem_we), 32'd0);
        chk("arst_addr", 32'(imem_addr), 32'd0);
        chk("arst_wd", imem_wd, 32'd0);
        chk("arst_core_reset", 32'(core_reset), 32'd1);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_error", 32'(error), 32'd0);
        @(posedge clk);
        #1;
        Reset = 1'b0;
        stream = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        add_cs(1, 8'h00);
        run_stream(1'b0);

        // start wins over a data byte accepted in the same cycle.
        start_pulse();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        in_data  = 8'h44;
        in_valid = 1'b1;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
        chk("drop_we", 32'(imem_we), 32'd0);
        chk("drop_in_ready", 32'(in_ready), 32'd1);
        chk("drop_core_reset", 32'(core_reset), 32'd1);
        chk("drop_done", 32'(done), 32'd0);
        chk("drop_error", 32'(error), 32'd0);
        // Counters must restart from zero: the next word goes to address 0.
        stream = '{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        add_cs(1, 8'h00);
        run_stream(1'b0);

        // Randomized frames with gaps, garbage, bad lengths and checksums.
        for (int t = 0; t < 24; t++) begin
            int n;
            logic [7:0] flip;
            start_pulse();
            n = $urandom_range(0, 6);
            if ($urandom_range(0, 7) == 0) n = $urandom_range(MAXW + 1, 1000);
            flip = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
            build_frame(n, $urandom_range(0, 3), flip);
            run_stream(1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_prog_loader
`default_nettype wire
